// File: rtl/vend_pkg.sv
// vend_pkg: shared coin/state types, coin values and widths for the
// vending machine change FSM (vend_change_fsm).
package vend_pkg;

  localparam int CREDIT_W = 5;
  localparam int CHANGE_W = 4;
  localparam int TIMER_W  = 8;

  localparam logic [CREDIT_W-1:0] COIN_VAL_1  = 5'd1;
  localparam logic [CREDIT_W-1:0] COIN_VAL_5  = 5'd5;
  localparam logic [CREDIT_W-1:0] COIN_VAL_10 = 5'd10;

  typedef enum logic [1:0] {
    COIN_1       = 2'b00,
    COIN_5       = 2'b01,
    COIN_10      = 2'b10,
    COIN_INVALID = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_SHOW
  } state_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input coin_t c);
    case (c)
      COIN_1:  return COIN_VAL_1;
      COIN_5:  return COIN_VAL_5;
      COIN_10: return COIN_VAL_10;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// vend_hold_timer: loadable down-counter that raises done for the single
// cycle in which the count sits at one, i.e. the last cycle of the hold.
module vend_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Reload when the display phase begins, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/vend_change_fsm.sv
// vend_change_fsm: coin collection, vend and change display controller.
// Optional feature: define VEND_CANCEL_EN to let a cancel pulse in COLLECT
// refund the accumulated credit; without it the cancel port is ignored.
module vend_change_fsm
  import vend_pkg::*;
#(
  parameter int PRICE       = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic [CHANGE_W-1:0] change_code,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [TIMER_W-1:0]  HOLD_V  = TIMER_W'(HOLD_CYCLES);

  state_t                state;
  coin_t                 coin;
  logic [CREDIT_W-1:0]   sum;
  logic                  cancel_hit;
  logic                  timer_load;
  logic                  timer_done;

  assign coin = coin_t'(coin_type);
  assign sum  = credit + coin_value(coin);

`ifdef VEND_CANCEL_EN
  assign cancel_hit = cancel && (state == S_COLLECT);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  assign timer_load = (state == S_VEND) || cancel_hit;

  vend_hold_timer #(
    .WIDTH(TIMER_W)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(HOLD_V),
    .done      (timer_done)
  );

  // Main controller: credit accumulation, vend/refund decisions and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend         <= 1'b0;
      change_code  <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      unique case (state)
        S_IDLE, S_COLLECT: begin
          if (cancel_hit) begin
            change_code  <= CHANGE_W'(credit);
            credit       <= '0;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            coin_reject  <= coin_valid;
            state        <= S_SHOW;
          end else if (coin_valid) begin
            if (coin == COIN_INVALID) begin
              coin_reject <= 1'b1;
            end else if (sum < PRICE_V) begin
              credit <= sum;
              state  <= S_COLLECT;
            end else begin
              change_code  <= CHANGE_W'(sum - PRICE_V);
              credit       <= '0;
              vend         <= 1'b1;
              change_valid <= 1'b1;
              busy         <= 1'b1;
              state        <= S_VEND;
            end
          end
        end
        S_VEND: begin
          coin_reject <= coin_valid;
          state       <= S_SHOW;
        end
        S_SHOW: begin
          coin_reject <= coin_valid;
          if (timer_done) begin
            change_code  <= '0;
            change_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_fsm.sv
// tb_vend_change_fsm: directed scoreboard bench for vend_change_fsm with
// PRICE=7 and HOLD_CYCLES=4. Honours VEND_CANCEL_EN like the design.
module tb_vend_change_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic [4:0] credit;
  logic       vend;
  logic [3:0] change_code;
  logic       change_valid;
  logic       coin_reject;
  logic       busy;

  typedef struct {
    logic [4:0] credit;
    logic       vend;
    logic [3:0] change_code;
    logic       change_valid;
    logic       coin_reject;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  vend_change_fsm #(
    .PRICE(7),
    .HOLD_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .cancel      (cancel),
    .credit      (credit),
    .vend        (vend),
    .change_code (change_code),
    .change_valid(change_valid),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int cr, input logic v, input int cc,
                              input logic cv, input logic rj, input logic b);
    exp_t e;
    e.credit       = 5'(cr);
    e.vend         = v;
    e.change_code  = 4'(cc);
    e.change_valid = cv;
    e.coin_reject  = rj;
    e.busy         = b;
    return e;
  endfunction

  task automatic cmp(input string tag, input string field, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("[TB] FAIL %s.scoreboard: observed empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "credit",       int'(credit),       int'(e.credit));
    cmp(tag, "vend",         int'(vend),         int'(e.vend));
    cmp(tag, "change_code",  int'(change_code),  int'(e.change_code));
    cmp(tag, "change_valid", int'(change_valid), int'(e.change_valid));
    cmp(tag, "coin_reject",  int'(coin_reject),  int'(e.coin_reject));
    cmp(tag, "busy",         int'(busy),         int'(e.busy));
  endtask

  // Drive one cycle of inputs, record what the next edge must produce, then check it
  task automatic applyStimulus(input string tag, input logic cv, input logic [1:0] ct,
                               input logic cn, input exp_t e);
    sb.push_back(e);
    coin_valid = cv;
    coin_type  = ct;
    cancel     = cn;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    cancel     = 1'b0;
    checkOutput(tag);
  endtask

  task automatic idleStep(input string tag, input exp_t e);
    applyStimulus(tag, 1'b0, 2'b00, 1'b0, e);
  endtask

  // Remaining display cycles with the given change, then the return to IDLE
  task automatic holdThenIdle(input string tag, input int n, input int cc);
    for (int i = 0; i < n; i++) idleStep(tag, mk(0, 0, cc, 1, 0, 1));
    idleStep({tag, "_idle"}, mk(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    cancel     = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    checkOutput("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 5,1,1 -> exact price, no change, change_valid for VEND + 4 SHOW cycles
    applyStimulus("r032_c5",   1'b1, 2'b01, 1'b0, mk(5, 0, 0, 0, 0, 0));
    applyStimulus("r032_c1a",  1'b1, 2'b00, 1'b0, mk(6, 0, 0, 0, 0, 0));
    applyStimulus("r032_vend", 1'b1, 2'b00, 1'b0, mk(0, 1, 0, 1, 0, 1));
    holdThenIdle("r032_show", 4, 0);

    // 5,5 -> change 3, with a coin rejected during SHOW without disturbing the timer
    applyStimulus("r033_c5",   1'b1, 2'b01, 1'b0, mk(5, 0, 0, 0, 0, 0));
    applyStimulus("r033_vend", 1'b1, 2'b01, 1'b0, mk(0, 1, 3, 1, 0, 1));
    idleStep("r033_show1", mk(0, 0, 3, 1, 0, 1));
    applyStimulus("r035_show_rej", 1'b1, 2'b00, 1'b0, mk(0, 0, 3, 1, 1, 1));
    holdThenIdle("r033_show", 2, 3);

    // Invalid coin in IDLE and cancel in IDLE
    applyStimulus("r035_invalid", 1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 1, 0));
    idleStep("r035_after", mk(0, 0, 0, 0, 0, 0));
    applyStimulus("idle_cancel", 1'b0, 2'b00, 1'b1, mk(0, 0, 0, 0, 0, 0));

    // Six 1-unit coins then a 10 -> maximum change of 9
    for (int i = 1; i <= 6; i++)
      applyStimulus($sformatf("r034_c1_%0d", i), 1'b1, 2'b00, 1'b0, mk(i, 0, 0, 0, 0, 0));
    applyStimulus("r034_vend", 1'b1, 2'b10, 1'b0, mk(0, 1, 9, 1, 0, 1));
    holdThenIdle("r034_show", 4, 9);

    // Cancel with a simultaneous coin in COLLECT
    applyStimulus("r036_c5", 1'b1, 2'b01, 1'b0, mk(5, 0, 0, 0, 0, 0));
`ifdef VEND_CANCEL_EN
    applyStimulus("r036_refund", 1'b1, 2'b00, 1'b1, mk(0, 0, 5, 1, 1, 1));
    holdThenIdle("r036_show", 3, 5);
`else
    applyStimulus("r036_nocancel", 1'b1, 2'b00, 1'b1, mk(6, 0, 0, 0, 0, 0));
    applyStimulus("r036_vend", 1'b1, 2'b00, 1'b0, mk(0, 1, 0, 1, 0, 1));
    holdThenIdle("r036_show", 4, 0);
`endif

    // Reset in the second SHOW cycle clears outputs without a clock edge
    applyStimulus("r037_c5",    1'b1, 2'b01, 1'b0, mk(5, 0, 0, 0, 0, 0));
    applyStimulus("r037_vend",  1'b1, 2'b01, 1'b0, mk(0, 1, 3, 1, 0, 1));
    idleStep("r037_show1", mk(0, 0, 3, 1, 0, 1));
    idleStep("r037_show2", mk(0, 0, 3, 1, 0, 1));
    #2;
    reset = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    checkOutput("r037_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus("r037_c5_after", 1'b1, 2'b01, 1'b0, mk(5, 0, 0, 0, 0, 0));
    idleStep("r037_novend1", mk(5, 0, 0, 0, 0, 0));
    idleStep("r037_novend2", mk(5, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vend_change_fsm.md
VEND_CHANGE_FSM -- requirements
Module: vend_change_fsm

Interface
REQ-001 Parameter PRICE, default 7, item price in credit units; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 4, number of cycles change is held for display after vend/refund; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coin_valid  input  1  one-cycle pulse, coin inserted.
REQ-006 coin_type  input  2  00=1 unit, 01=5 units, 10=10 units, 11=invalid.
REQ-007 cancel  input  1  one-cycle pulse, customer requests refund.
REQ-008 credit  output  5  current accumulated credit.
REQ-009 vend  output  1  one-cycle pulse, dispense item.
REQ-010 change_code  output  4  change/refund amount, binary 0..9, feeds the change seven-segment decoder.
REQ-011 change_valid  output  1  high while change_code is being displayed.
REQ-012 coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-013 busy  output  1  high in VEND and SHOW states.

Function
REQ-014 States SHALL be IDLE (credit 0), COLLECT (0<credit<PRICE), VEND (one cycle), SHOW (HOLD_CYCLES cycles).
REQ-015 IDLE/COLLECT, valid coin, sum=credit+value<PRICE: credit<=sum next edge, state COLLECT.
REQ-016 IDLE/COLLECT, valid coin, sum>=PRICE: next edge state VEND, change_code<=sum-PRICE, credit<=0.
REQ-017 vend SHALL be 1 exactly during the VEND cycle; next state SHOW.
REQ-018 change_valid SHALL be 1 in VEND and every SHOW cycle, so total HOLD_CYCLES+1 cycles.
REQ-019 SHOW SHALL exit to IDLE after HOLD_CYCLES cycles, clearing change_code to 0 on that edge.
REQ-020 coin_type 11 in any state: coin_reject pulse the next cycle, credit unchanged.
REQ-021 Any coin_valid in VEND or SHOW: coin_reject pulse the next cycle, credit and timer unchanged.
REQ-022 Arithmetic: sum computed at 5 bits (max PRICE-1+10=24, no overflow); change_code = sum-PRICE <= 9.
REQ-023 cancel in COLLECT: next edge change_code<=credit, credit<=0, state SHOW (no VEND, vend stays 0).
REQ-024 cancel in IDLE, VEND, SHOW: ignored.
REQ-025 cancel and coin_valid same cycle in COLLECT: cancel wins, coin rejected (coin_reject next cycle), refund = pre-coin credit.

Reset
REQ-026 reset asserted: state IDLE, credit 0, change_code 0, vend 0, change_valid 0, coin_reject 0, busy 0, hold timer 0, immediately and asynchronously.
REQ-027 reset mid-VEND or mid-SHOW SHALL abort display with no further vend pulse after release.

Configuration
REQ-028 Macro VEND_CANCEL_EN defined: cancel behaves per REQ-023..025.
REQ-029 VEND_CANCEL_EN undefined: cancel port present but ignored in all states; simultaneous coin is processed normally.

Structure
REQ-030 Package vend_pkg SHALL hold the coin_type enum, the state enum, coin value constants (1, 5, 10) and the change_code width.
REQ-031 Hold countdown SHALL be a sub-module vend_hold_timer (load, count-down, done pulse, async reset).

Verification (PRICE=7, HOLD_CYCLES=4)
REQ-032 Coins 5,1,1 on separate cycles -> credit 5,6; vend pulse one cycle after third coin; change_code 0; change_valid 5 cycles.
REQ-033 Coins 5,5 -> vend once, change_code 3 for 5 cycles, then 0 and state IDLE.
REQ-034 Six 1-unit coins then a 10 -> credit 6, then vend with change_code 9.
REQ-035 Coin 1 during SHOW, and coin_type 11 in IDLE -> coin_reject pulse each, credit and change_code unchanged.
REQ-036 Coin 5 then cancel with coin 1 same cycle -> with VEND_CANCEL_EN change_code 5, vend 0, coin_reject 1; without it credit 6 and no refund.
REQ-037 reset asserted in second SHOW cycle -> all outputs 0 without waiting for a clock edge; next coin 5 gives credit 5.
